// File: rtl/fitness_eval_scheduler.sv
// Fitness evaluation scheduler: walks the GA population one individual at a
// time through a shared fitness calculator. For each one it issues a start,
// waits for done (or times out), writes the result to the fitness table, and
// tracks the best individual. At the end it pulses gen_done to the GA controller.
module fitness_eval_scheduler #(
  parameter int unsigned POP_SIZE        = 16,
  parameter int unsigned IDX_W           = $clog2(POP_SIZE),
  parameter int unsigned FIT_W           = 5,
  parameter int unsigned TIMEOUT         = 64,
  parameter bit          STOP_ON_PERFECT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_start,
  input  logic             abort,
  output logic [IDX_W-1:0] ind_idx,
  output logic             fc_start,
  input  logic             fc_done,
  input  logic [FIT_W-1:0] fc_fitness,
  output logic             fit_we,
  output logic [IDX_W-1:0] fit_addr,
  output logic [FIT_W-1:0] fit_data,
  output logic             busy,
  output logic             gen_done,
  output logic [IDX_W-1:0] best_idx,
  output logic [FIT_W-1:0] best_fitness,
  output logic             perfect,
  output logic             timeout_err
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POP_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_FINISH
  } state_e;

  state_e           state_q,    state_d;
  logic [IDX_W-1:0] idx_q,      idx_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [FIT_W-1:0] cap_q,      cap_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [FIT_W-1:0] best_fit_q, best_fit_d;
  logic             perfect_q,  perfect_d;
  logic             tmo_q,      tmo_d;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      cap_q      <= '0;
      best_idx_q <= '0;
      best_fit_q <= '1;
      perfect_q  <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      best_idx_q <= best_idx_d;
      best_fit_q <= best_fit_d;
      perfect_q  <= perfect_d;
      tmo_q      <= tmo_d;
    end
  end

  // Next-state and strobe logic. An abort in any active state overrides every
  // other event, so it is tested before the per-state actions.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    best_idx_d = best_idx_q;
    best_fit_d = best_fit_q;
    perfect_d  = perfect_q;
    tmo_d      = tmo_q;
    fc_start   = 1'b0;
    fit_we     = 1'b0;
    gen_done   = 1'b0;

    if (state_q == S_IDLE) begin
      if (gen_start && !abort) begin
        idx_d      = '0;
        perfect_d  = 1'b0;
        tmo_d      = 1'b0;
        best_fit_d = '1;
        best_idx_d = '0;
        state_d    = S_ISSUE;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_ISSUE: begin
          fc_start = 1'b1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          // The first WAIT cycle ignores fc_done; the calculator clears it on the start edge.
          if ((cnt_q != '0) && fc_done) begin
            cap_d   = fc_fitness;
            state_d = S_STORE;
          end else if (cnt_q == CNT_LAST) begin
            cap_d   = '1;
            tmo_d   = 1'b1;
            state_d = S_STORE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_STORE: begin
          fit_we = 1'b1;
          if (cap_q < best_fit_q) begin
            best_idx_d = idx_q;
            best_fit_d = cap_q;
          end
          if (cap_q == '0) begin
            perfect_d = 1'b1;
          end
          if ((idx_q == LAST_IDX) || (STOP_ON_PERFECT && (cap_q == '0))) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_FINISH: begin
          gen_done = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ind_idx      = idx_q;
  assign fit_addr     = idx_q;
  assign fit_data     = cap_q;
  assign busy         = (state_q != S_IDLE);
  assign best_idx     = best_idx_q;
  assign best_fitness = best_fit_q;
  assign perfect      = perfect_q;
  assign timeout_err  = tmo_q;

endmodule
